ahb_mem_arbiter: RTL and testbench
==================================

Name: ahb_mem_arbiter

Overview:
Shares one memory-side port (valid / rd0_wr1 / addr / wr_data, with ready / rd_valid / rd_data) between NUM_REQ requesters. Typical requesters are AHB slave front-ends or DMA engines. Arbitration is round-robin and one transaction is outstanding at a time. Read returns are routed back to the granted requester, and a watchdog terminates reads that the memory never answers.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
DATA_WIDTH, 32, data width of write and read data
ADDR_WIDTH, 32, address width
RD_TIMEOUT, 255, maximum cycles spent in WAIT_RD before an error completion; 0 disables the watchdog

Ports:
i_clk_ahb  in  1  clock
i_rstn_ahb  in  1  async active-low reset
i_req_valid  in  NUM_REQ  per-requester request valid; held until o_req_ready is seen
i_req_rd0_wr1  in  NUM_REQ  per-requester direction, 1 = write
i_req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester k occupies [k*ADDR_WIDTH +: ADDR_WIDTH]
i_req_wr_data  in  NUM_REQ*DATA_WIDTH  packed write data, same packing rule
o_req_ready  out  NUM_REQ  one-cycle pulse: request captured
o_req_rd_valid  out  NUM_REQ  one-cycle pulse: read completed for requester k
o_req_rd_data  out  DATA_WIDTH  shared read data; valid only while some o_req_rd_valid bit is 1
o_req_err  out  NUM_REQ  pulses together with o_req_rd_valid when a read times out
o_valid  out  1  memory transaction valid
o_rd0_wr1  out  1  memory direction, 1 = write
o_addr  out  ADDR_WIDTH  memory address
o_wr_data  out  DATA_WIDTH  memory write data
i_ready  in  1  memory accepts the transaction when o_valid & i_ready
i_rd_valid  in  1  memory read data valid
i_rd_data  in  DATA_WIDTH  memory read data
o_busy  out  1  1 whenever the state is not IDLE

Behaviour:
- Clocking: one clock, i_clk_ahb. Reset i_rstn_ahb is asynchronous and active-low.
- Reset values:
  - State = IDLE, last_grant = NUM_REQ-1, so requester 0 wins first.
  - All outputs are 0, and the captured payload registers are 0.
- States: IDLE, ISSUE, WAIT_RD.
- IDLE:
  - If any i_req_valid bit is set, the winner is the first set bit searching upward from last_grant+1, wrapping modulo NUM_REQ.
  - o_req_ready[winner] = 1 combinationally in that cycle.
  - On that edge: capture the winner's addr, data and direction plus the grant index; last_grant <= winner; go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE:
  - o_valid = 1; o_rd0_wr1, o_addr and o_wr_data are driven from the captured registers.
  - The outputs hold stable until i_ready = 1.
  - When i_ready = 1 and the transaction is a write, go to IDLE. There is no response to the requester.
  - When i_ready = 1 and it is a read with i_rd_valid = 0, go to WAIT_RD and clear the timeout counter.
  - When i_ready = 1 and it is a read with i_rd_valid = 1 in the same cycle, complete immediately (see the completion rule) and go to IDLE.
- WAIT_RD:
  - o_valid = 0.
  - When i_rd_valid = 1: o_req_rd_data is registered from i_rd_data, o_req_rd_valid[grant] pulses 1 in the next cycle, and the state goes to IDLE.
  - The counter increments every cycle while in WAIT_RD. When it reaches RD_TIMEOUT (and RD_TIMEOUT != 0), the block pulses o_req_rd_valid[grant] and o_req_err[grant] with o_req_rd_data = 0, then goes to IDLE.
  - If i_rd_valid and the timeout occur in the same cycle, i_rd_valid wins and there is no error.
- Completion outputs (o_req_rd_valid, o_req_err, o_req_rd_data) are registered. The pulse lasts exactly one cycle and coincides with the return to IDLE, so a new grant can be issued in that same cycle.
- i_rd_valid is ignored in IDLE, and in ISSUE before acceptance (stray pulses are dropped).
- Latency:
  - Request to o_valid: 1 cycle.
  - Back-to-back writes with i_ready = 1 permanently: one accepted every 2 cycles.
  - Read with single-cycle memory: o_req_rd_valid 3 cycles after o_req_ready.
- Fairness: a requester that holds valid is granted within NUM_REQ transactions.
- Dropped requests: deasserting i_req_valid before ready is legal. That request is simply not granted.
- Reset mid-operation: the in-flight transaction is abandoned with no completion pulse. A late i_rd_valid after reset is ignored.
- Counter width: $clog2(RD_TIMEOUT+1), minimum 1 bit. The counter saturates and never wraps.

Decomposition:
- Package ahb_mem_arb_pkg holds arb_state_t (IDLE/ISSUE/WAIT_RD) and a localparam function for the counter width.
- Sub-module rr_arbiter (NUM_REQ): purely combinational. Inputs are the request vector and last_grant; outputs are a one-hot grant and its index.
- All state lives in ahb_mem_arbiter.

Test Plan:
- Single write: req0 writes addr 0x100, data 0xDEADBEEF, i_ready = 1 → o_req_ready[0] at cycle 0; o_valid/o_rd0_wr1 = 1, o_addr = 0x100, o_wr_data = 0xDEADBEEF at cycle 1; IDLE at cycle 2.
- Read with wait states: req1 reads 0x40, i_ready held low 3 cycles, i_rd_valid 2 cycles after accept with 0x12345678 → o_valid held stable for 4 cycles; o_req_rd_valid[1] single pulse with 0x12345678; o_req_err = 0.
- Round-robin: both requesters hold continuous writes for 6 transactions → grant order 0,1,0,1,0,1.
- Timeout: RD_TIMEOUT = 4, read accepted, i_rd_valid never arrives → o_req_rd_valid[0] and o_req_err[0] pulse together, o_req_rd_data = 0, state returns to IDLE.
- Same-cycle read completion plus stray rd_valid: i_ready and i_rd_valid both 1 in ISSUE with 0xA5A5A5A5 → completion pulse next cycle. A stray i_rd_valid in IDLE produces no pulse.
- Reset in WAIT_RD: assert i_rstn_ahb low mid-read, release, then drive i_rd_valid → all outputs 0, no o_req_rd_valid pulse, next grant goes to requester 0.

Source files
------------

// File: rtl/ahb_mem_arb_pkg.sv
// Shared types and sizing helpers for the memory-port arbiter.
// Holds the FSM state encoding and width functions for counters and indices.
package ahb_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } arb_state_t;

    // Width of the read watchdog counter; never below one bit.
    function automatic int cnt_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // Width of a requester index; never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request above last_grant, wrapping.
// Ports: i_req, i_last_grant in; o_gnt (one-hot), o_gnt_idx, o_gnt_valid out.
module rr_arbiter
    import ahb_mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IW      = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_last_grant,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IW-1:0]      o_gnt_idx,
    output logic               o_gnt_valid
);

    always_comb begin
        int  idx;
        logic found;
        o_gnt     = '0;
        o_gnt_idx = '0;
        found     = 1'b0;
        idx       = 0;
        // Scan starting just after the previous winner so it has lowest priority.
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(i_last_grant) + i) % NUM_REQ;
            if (!found && i_req[idx]) begin
                found      = 1'b1;
                o_gnt[idx] = 1'b1;
                o_gnt_idx  = IW'(idx);
            end
        end
        o_gnt_valid = found;
    end

endmodule

// File: rtl/ahb_mem_arbiter.sv
// Round-robin share of one memory port among NUM_REQ requesters, one op in flight.
// Ports: per-requester req/ready/rd_valid/err, memory valid/ready/rd_valid side, o_busy.
module ahb_mem_arbiter
    import ahb_mem_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int RD_TIMEOUT = 255
) (
    input  logic                          i_clk_ahb,
    input  logic                          i_rstn_ahb,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ-1:0]            i_req_rd0_wr1,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_wr_data,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic [NUM_REQ-1:0]            o_req_rd_valid,
    output logic [DATA_WIDTH-1:0]         o_req_rd_data,
    output logic [NUM_REQ-1:0]            o_req_err,
    output logic                          o_valid,
    output logic                          o_rd0_wr1,
    output logic [ADDR_WIDTH-1:0]         o_addr,
    output logic [DATA_WIDTH-1:0]         o_wr_data,
    input  logic                          i_ready,
    input  logic                          i_rd_valid,
    input  logic [DATA_WIDTH-1:0]         i_rd_data,
    output logic                          o_busy
);

    localparam int IW = idx_width(NUM_REQ);
    localparam int CW = cnt_width(RD_TIMEOUT);
    localparam logic [CW-1:0] TO_VAL  = CW'(RD_TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);

    arb_state_t              state_q, state_d;
    logic [IW-1:0]           last_grant_q, last_grant_d;
    logic [IW-1:0]           grant_q, grant_d;
    logic                    rw_q, rw_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [NUM_REQ-1:0]      rd_valid_q, rd_valid_d;
    logic [NUM_REQ-1:0]      err_q, err_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;

    logic [NUM_REQ-1:0]      gnt;
    logic [IW-1:0]           gnt_idx;
    logic                    gnt_valid;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr (
        .i_req        (i_req_valid),
        .i_last_grant (last_grant_q),
        .o_gnt        (gnt),
        .o_gnt_idx    (gnt_idx),
        .o_gnt_valid  (gnt_valid)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        rw_d         = rw_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        // Completion outputs default low so every pulse lasts one cycle.
        rd_valid_d   = '0;
        err_d        = '0;
        rd_data_d    = '0;
        unique case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    grant_d      = gnt_idx;
                    last_grant_d = gnt_idx;
                    rw_d         = i_req_rd0_wr1[gnt_idx];
                    addr_d       = i_req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d      = i_req_wr_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (i_ready) begin
                    if (rw_q) begin
                        state_d = IDLE;
                    end else if (i_rd_valid) begin
                        rd_valid_d[grant_q] = 1'b1;
                        rd_data_d           = i_rd_data;
                        state_d             = IDLE;
                    end else begin
                        cnt_d   = '0;
                        state_d = WAIT_RD;
                    end
                end
            end
            WAIT_RD: begin
                // Real data beats the watchdog when both land together.
                if (i_rd_valid) begin
                    rd_valid_d[grant_q] = 1'b1;
                    rd_data_d           = i_rd_data;
                    state_d             = IDLE;
                end else if (RD_TIMEOUT != 0 && cnt_q == TO_VAL) begin
                    rd_valid_d[grant_q] = 1'b1;
                    err_d[grant_q]      = 1'b1;
                    state_d             = IDLE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
        if (!i_rstn_ahb) begin
            state_q      <= IDLE;
            last_grant_q <= LAST_RST;
            grant_q      <= '0;
            rw_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            rd_valid_q   <= '0;
            err_q        <= '0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            rw_q         <= rw_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            rd_valid_q   <= rd_valid_d;
            err_q        <= err_d;
            rd_data_q    <= rd_data_d;
        end
    end

    assign o_req_ready    = (state_q == IDLE) ? gnt : '0;
    assign o_req_rd_valid = rd_valid_q;
    assign o_req_err      = err_q;
    assign o_req_rd_data  = rd_data_q;
    assign o_valid        = (state_q == ISSUE);
    assign o_rd0_wr1      = rw_q;
    assign o_addr         = addr_q;
    assign o_wr_data      = wdata_q;
    assign o_busy         = (state_q != IDLE);

endmodule

// File: tb/tb_ahb_mem_arbiter.sv
// Directed bench for ahb_mem_arbiter (NUM_REQ=2, RD_TIMEOUT=4).
// Inputs change and outputs are checked 1-2 time units after each rising edge.
module tb_ahb_mem_arbiter;

    localparam int NR = 2;
    localparam int DW = 32;
    localparam int AW = 32;

    logic             clk;
    logic             rst_n;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_rw;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0]    req_rd_valid;
    logic [DW-1:0]    req_rd_data;
    logic [NR-1:0]    req_err;
    logic             m_valid;
    logic             m_rw;
    logic [AW-1:0]    m_addr;
    logic [DW-1:0]    m_wdata;
    logic             m_ready;
    logic             m_rd_valid;
    logic [DW-1:0]    m_rd_data;
    logic             busy;

    int n_assert = 0;
    int n_fail   = 0;

    ahb_mem_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .RD_TIMEOUT (4)
    ) dut (
        .i_clk_ahb      (clk),
        .i_rstn_ahb     (rst_n),
        .i_req_valid    (req_valid),
        .i_req_rd0_wr1  (req_rw),
        .i_req_addr     (req_addr),
        .i_req_wr_data  (req_wdata),
        .o_req_ready    (req_ready),
        .o_req_rd_valid (req_rd_valid),
        .o_req_rd_data  (req_rd_data),
        .o_req_err      (req_err),
        .o_valid        (m_valid),
        .o_rd0_wr1      (m_rw),
        .o_addr         (m_addr),
        .o_wr_data      (m_wdata),
        .i_ready        (m_ready),
        .i_rd_valid     (m_rd_valid),
        .i_rd_data      (m_rd_data),
        .o_busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst_n      = 1'b0;
        req_valid  = '0;
        req_rw     = '0;
        req_addr   = '0;
        req_wdata  = '0;
        m_ready    = 1'b0;
        m_rd_valid = 1'b0;
        m_rd_data  = '0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_addr", m_addr, 0);
        chk("rst_wdata", m_wdata, 0);
        chk("rst_rdv", req_rd_valid, 0);
        chk("rst_err", req_err, 0);
        chk("rst_rdata", req_rd_data, 0);
        rst_n = 1'b1;
        tick();

        // Single write from requester 0
        req_valid        = 2'b01;
        req_rw           = 2'b01;
        req_addr[0+:AW]  = 32'h100;
        req_wdata[0+:DW] = 32'hDEADBEEF;
        m_ready          = 1'b1;
        #1;
        chk("wr_ready", req_ready, 2'b01);
        tick();
        req_valid = '0;
        #1;
        chk("wr_valid", m_valid, 1);
        chk("wr_dir", m_rw, 1);
        chk("wr_addr", m_addr, 32'h100);
        chk("wr_data", m_wdata, 32'hDEADBEEF);
        chk("wr_noready", req_ready, 0);
        tick();
        chk("wr_idle", busy, 0);
        chk("wr_valid_off", m_valid, 0);

        // Read from requester 1 with memory wait states
        m_ready          = 1'b0;
        req_valid        = 2'b10;
        req_rw           = 2'b00;
        req_addr[AW+:AW] = 32'h40;
        #1;
        chk("rd_ready", req_ready, 2'b10);
        tick();
        req_valid = '0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rd_hold_valid", m_valid, 1);
            chk("rd_hold_addr", m_addr, 32'h40);
            chk("rd_hold_dir", m_rw, 0);
            tick();
        end
        m_ready = 1'b1;
        #1;
        chk("rd_acc_valid", m_valid, 1);
        tick();
        m_ready = 1'b0;
        #1;
        chk("rd_wait_valid", m_valid, 0);
        chk("rd_wait_busy", busy, 1);
        chk("rd_wait_rdv", req_rd_valid, 0);
        tick();
        m_rd_valid = 1'b1;
        m_rd_data  = 32'h12345678;
        tick();
        m_rd_valid = 1'b0;
        m_rd_data  = '0;
        #1;
        chk("rd_done_rdv", req_rd_valid, 2'b10);
        chk("rd_done_data", req_rd_data, 32'h12345678);
        chk("rd_done_err", req_err, 0);
        chk("rd_done_idle", busy, 0);
        tick();
        chk("rd_pulse_end", req_rd_valid, 0);

        // Round-robin with both requesters writing continuously
        req_valid        = 2'b11;
        req_rw           = 2'b11;
        req_addr[0+:AW]  = 32'h200;
        req_addr[AW+:AW] = 32'h300;
        m_ready          = 1'b1;
        for (int t = 0; t < 6; t++) begin
            #1;
            chk("rr_ready", req_ready, (t % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            chk("rr_addr", m_addr, (t % 2 == 0) ? 32'h200 : 32'h300);
            tick();
        end
        req_valid = '0;

        // Read timeout on requester 0
        req_valid       = 2'b01;
        req_rw          = 2'b00;
        req_addr[0+:AW] = 32'h80;
        #1;
        chk("to_ready", req_ready, 2'b01);
        tick();
        req_valid = '0;
        chk("to_issue", m_valid, 1);
        tick();
        m_ready = 1'b0;
        chk("to_wait_busy", busy, 1);
        n = 0;
        while (req_rd_valid == '0 && n < 20) begin
            tick();
            n++;
        end
        chk("to_cycles", n, 5);
        chk("to_rdv", req_rd_valid, 2'b01);
        chk("to_err", req_err, 2'b01);
        chk("to_data", req_rd_data, 0);
        chk("to_idle", busy, 0);
        tick();
        chk("to_err_end", req_err, 0);

        // Same-cycle read completion, then a stray rd_valid in IDLE
        req_valid        = 2'b10;
        req_rw           = 2'b00;
        req_addr[AW+:AW] = 32'hC0;
        #1;
        chk("sc_ready", req_ready, 2'b10);
        tick();
        req_valid  = '0;
        m_ready    = 1'b1;
        m_rd_valid = 1'b1;
        m_rd_data  = 32'hA5A5A5A5;
        #1;
        chk("sc_valid", m_valid, 1);
        tick();
        m_ready    = 1'b0;
        m_rd_valid = 1'b0;
        #1;
        chk("sc_rdv", req_rd_valid, 2'b10);
        chk("sc_data", req_rd_data, 32'hA5A5A5A5);
        chk("sc_err", req_err, 0);
        chk("sc_idle", busy, 0);
        tick();
        m_rd_valid = 1'b1;
        m_rd_data  = 32'hFFFF0000;
        tick();
        m_rd_valid = 1'b0;
        #1;
        chk("stray_rdv", req_rd_valid, 0);
        chk("stray_busy", busy, 0);

        // Reset while waiting for read data
        req_valid       = 2'b01;
        req_rw          = 2'b00;
        req_addr[0+:AW] = 32'h44;
        #1;
        chk("rs_ready", req_ready, 2'b01);
        tick();
        req_valid = '0;
        m_ready   = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("rs_wait", busy, 1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rs_busy", busy, 0);
        chk("rs_valid", m_valid, 0);
        chk("rs_addr", m_addr, 0);
        chk("rs_rdv", req_rd_valid, 0);
        tick();
        rst_n      = 1'b1;
        m_rd_valid = 1'b1;
        m_rd_data  = 32'h55;
        tick();
        m_rd_valid = 1'b0;
        chk("rs_late_rdv", req_rd_valid, 0);
        tick();
        chk("rs_late_rdv2", req_rd_valid, 0);
        req_valid = 2'b11;
        req_rw    = 2'b11;
        #1;
        chk("rs_first_grant", req_ready, 2'b01);
        req_valid = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
